// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the AXI bridge write/read ordering logic.
package axi_bridge_pkg;

    typedef struct packed {
        logic       master;
        logic [2:0] slave;
        logic [3:0] len;
    } aw_entry_t;

    localparam logic [2:0] SLV_DEFAULT = 3'd6;
    localparam logic       MST_M1      = 1'b0;
    localparam logic       MST_M2      = 1'b1;

endpackage

// File: rtl/axi_sync_fifo.sv
// DEPTH x WIDTH register FIFO with registered full/empty flags.
module axi_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en, rd_en;

    // A push while full is only taken when a pop frees the slot in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign cnt_nxt = cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/axi_wdata_router.sv
// W-channel router: steers beats from the AW-queue head's master to its slave.
module axi_wdata_router
    import axi_bridge_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aw_push,
    input  logic              aw_master,
    input  logic [2:0]        aw_slave,
    input  logic [3:0]        aw_len,
    output logic              aw_full,
    input  logic [DATA_W-1:0] WDATA_M1,
    input  logic [STRB_W-1:0] WSTRB_M1,
    input  logic              WLAST_M1,
    input  logic              WVALID_M1,
    output logic              WREADY_M1,
    input  logic [DATA_W-1:0] WDATA_M2,
    input  logic [STRB_W-1:0] WSTRB_M2,
    input  logic              WLAST_M2,
    input  logic              WVALID_M2,
    output logic              WREADY_M2,
    output logic [DATA_W-1:0] WDATA_S0, WDATA_S1, WDATA_S2, WDATA_S3, WDATA_S4, WDATA_S5,
    output logic [STRB_W-1:0] WSTRB_S0, WSTRB_S1, WSTRB_S2, WSTRB_S3, WSTRB_S4, WSTRB_S5,
    output logic              WLAST_S0, WLAST_S1, WLAST_S2, WLAST_S3, WLAST_S4, WLAST_S5,
    output logic              WVALID_S0, WVALID_S1, WVALID_S2, WVALID_S3, WVALID_S4, WVALID_S5,
    input  logic              WREADY_S0, WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4, WREADY_S5,
    output logic              ds_wdone,
    output logic              wlast_err
);
    aw_entry_t                    aw_in, head;
    logic [$bits(aw_entry_t)-1:0] head_bits;
    logic                         q_empty, hs, pop, is_def, slv_rdy;
    logic                         sel_valid, sel_last;
    logic [DATA_W-1:0]            sel_data;
    logic [STRB_W-1:0]            sel_strb;
    logic [3:0]                   cnt;

    logic [1:0]                   m_wvalid, m_wlast, m_wready;
    logic [1:0][DATA_W-1:0]       m_wdata;
    logic [1:0][STRB_W-1:0]       m_wstrb;
    logic [7:0]                   s_rdy_ext;
    logic [5:0]                   s_wvalid, s_wlast;
    logic [5:0][DATA_W-1:0]       s_wdata;
    logic [5:0][STRB_W-1:0]       s_wstrb;

    assign aw_in = '{master: aw_master, slave: aw_slave, len: aw_len};
    assign head  = aw_entry_t'(head_bits);

    axi_sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(aw_entry_t))) u_aw_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_push),
        .pop   (pop),
        .din   (aw_in),
        .dout  (head_bits),
        .full  (aw_full),
        .empty (q_empty)
    );

    assign m_wvalid  = {WVALID_M2, WVALID_M1};
    assign m_wlast   = {WLAST_M2, WLAST_M1};
    assign m_wdata   = {WDATA_M2, WDATA_M1};
    assign m_wstrb   = {WSTRB_M2, WSTRB_M1};
    assign s_rdy_ext = {2'b00, WREADY_S5, WREADY_S4, WREADY_S3, WREADY_S2, WREADY_S1, WREADY_S0};

    assign sel_valid = m_wvalid[head.master];
    assign sel_last  = m_wlast[head.master];
    assign sel_data  = m_wdata[head.master];
    assign sel_strb  = m_wstrb[head.master];
    // Slave codes 6 and 7 both sink into the internal default slave.
    assign is_def    = (head.slave >= SLV_DEFAULT);
    assign slv_rdy   = is_def ? 1'b1 : s_rdy_ext[head.slave];
    assign hs        = !q_empty && sel_valid && slv_rdy;
    assign pop       = hs && sel_last;

    always_comb begin
        m_wready = '0;
        s_wvalid = '0;
        s_wlast  = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        if (!q_empty) begin
            m_wready[head.master] = slv_rdy;
            for (int n = 0; n < 6; n++) begin
                if (!is_def && head.slave == 3'(n)) begin
                    s_wvalid[n] = sel_valid;
                    s_wlast[n]  = sel_last;
                    s_wdata[n]  = sel_data;
                    s_wstrb[n]  = sel_strb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            ds_wdone  <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            ds_wdone  <= pop && is_def;
            wlast_err <= hs && (sel_last != (cnt == head.len));
            if (pop)                     cnt <= '0;
            else if (hs && cnt != 4'hF) cnt <= cnt + 4'd1;
        end
    end

    assign WREADY_M1 = m_wready[MST_M1];
    assign WREADY_M2 = m_wready[MST_M2];
    assign {WVALID_S5, WVALID_S4, WVALID_S3, WVALID_S2, WVALID_S1, WVALID_S0} = s_wvalid;
    assign {WLAST_S5, WLAST_S4, WLAST_S3, WLAST_S2, WLAST_S1, WLAST_S0}       = s_wlast;
    assign {WDATA_S5, WDATA_S4, WDATA_S3, WDATA_S2, WDATA_S1, WDATA_S0}       = s_wdata;
    assign {WSTRB_S5, WSTRB_S4, WSTRB_S3, WSTRB_S2, WSTRB_S1, WSTRB_S0}       = s_wstrb;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Bench for axi_wdata_router: queue-based reference model plus directed scenarios.
module tb_axi_wdata_router;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_push, aw_master, aw_full;
    logic [2:0]  aw_slave;
    logic [3:0]  aw_len;
    logic [1:0]  wv_m, wl_m, wr_m;
    logic [31:0] wd_m [2];
    logic [3:0]  ws_m [2];
    logic [5:0]  wv_s, wl_s, wr_s;
    logic [31:0] wd_s [6];
    logic [3:0]  ws_s [6];
    logic        ds_wdone, wlast_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_wdata_router #(.DEPTH(DEPTH), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst),
        .aw_push(aw_push), .aw_master(aw_master), .aw_slave(aw_slave), .aw_len(aw_len),
        .aw_full(aw_full),
        .WDATA_M1(wd_m[0]), .WSTRB_M1(ws_m[0]), .WLAST_M1(wl_m[0]), .WVALID_M1(wv_m[0]), .WREADY_M1(wr_m[0]),
        .WDATA_M2(wd_m[1]), .WSTRB_M2(ws_m[1]), .WLAST_M2(wl_m[1]), .WVALID_M2(wv_m[1]), .WREADY_M2(wr_m[1]),
        .WDATA_S0(wd_s[0]), .WDATA_S1(wd_s[1]), .WDATA_S2(wd_s[2]),
        .WDATA_S3(wd_s[3]), .WDATA_S4(wd_s[4]), .WDATA_S5(wd_s[5]),
        .WSTRB_S0(ws_s[0]), .WSTRB_S1(ws_s[1]), .WSTRB_S2(ws_s[2]),
        .WSTRB_S3(ws_s[3]), .WSTRB_S4(ws_s[4]), .WSTRB_S5(ws_s[5]),
        .WLAST_S0(wl_s[0]), .WLAST_S1(wl_s[1]), .WLAST_S2(wl_s[2]),
        .WLAST_S3(wl_s[3]), .WLAST_S4(wl_s[4]), .WLAST_S5(wl_s[5]),
        .WVALID_S0(wv_s[0]), .WVALID_S1(wv_s[1]), .WVALID_S2(wv_s[2]),
        .WVALID_S3(wv_s[3]), .WVALID_S4(wv_s[4]), .WVALID_S5(wv_s[5]),
        .WREADY_S0(wr_s[0]), .WREADY_S1(wr_s[1]), .WREADY_S2(wr_s[2]),
        .WREADY_S3(wr_s[3]), .WREADY_S4(wr_s[4]), .WREADY_S5(wr_s[5]),
        .ds_wdone(ds_wdone), .wlast_err(wlast_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of outstanding writes and beats seen for the head.
    typedef struct {int m; int s; int len;} ent_t;
    ent_t q[$];
    int   beats = 0;
    logic exp_ds = 1'b0, exp_err = 1'b0;

    initial begin
        bit full_b, hs, last, def;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                beats = 0; exp_ds = 1'b0; exp_err = 1'b0;
            end else begin
                full_b = (q.size() >= DEPTH);
                hs = 0; last = 0; def = 0;
                exp_err = 1'b0;
                if (q.size() > 0) begin
                    def  = (q[0].s >= 6);
                    last = wl_m[q[0].m];
                    hs   = wv_m[q[0].m] && (def ? 1'b1 : wr_s[q[0].s]);
                    if (hs) exp_err = (last != (beats == q[0].len));
                end
                exp_ds = hs && last && def;
                if (hs && last) begin
                    void'(q.pop_front());
                    beats = 0;
                end else if (hs) begin
                    beats = (beats < 15) ? beats + 1 : 15;
                end
                if (aw_push && (!full_b || (hs && last)))
                    q.push_back('{int'(aw_master), int'(aw_slave), int'(aw_len)});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [1:0]  e_wr;
        logic [5:0]  e_wv;
        logic [36:0] e_bus [6];
        forever begin
            @(negedge clk);
            e_wr = '0; e_wv = '0;
            for (int n = 0; n < 6; n++) e_bus[n] = '0;
            if (q.size() > 0) begin
                if (q[0].s >= 6) begin
                    e_wr[q[0].m] = 1'b1;
                end else begin
                    e_wr[q[0].m]  = wr_s[q[0].s];
                    e_wv[q[0].s]  = wv_m[q[0].m];
                    e_bus[q[0].s] = {wl_m[q[0].m], ws_m[q[0].m], wd_m[q[0].m]};
                end
            end
            chk("aw_full", aw_full, (q.size() == DEPTH));
            chk("wready_m", wr_m, e_wr);
            chk("wvalid_s", wv_s, e_wv);
            for (int n = 0; n < 6; n++)
                chk($sformatf("s%0d_bus", n), {wl_s[n], ws_s[n], wd_s[n]}, e_bus[n]);
            chk("ds_wdone", ds_wdone, exp_ds);
            chk("wlast_err", wlast_err, exp_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aw_push = 0; aw_master = 0; aw_slave = 0; aw_len = 0;
        wv_m = 0; wl_m = 0; wr_s = 0;
        for (int i = 0; i < 2; i++) begin wd_m[i] = 0; ws_m[i] = 0; end
    endtask

    task automatic push(input logic m, input logic [2:0] s, input logic [3:0] l);
        aw_push = 1; aw_master = m; aw_slave = s; aw_len = l;
    endtask

    initial begin
        int got, errs;
        idle();
        rst = 0;
        step(); step();
        #2;
        chk("rst_full", aw_full, 0);
        chk("rst_wready", wr_m, 0);
        chk("rst_wvalid", wv_s, 0);
        chk("rst_pulses", {ds_wdone, wlast_err}, 0);
        rst = 1;
        step();

        // Single beat M1 -> S2
        push(0, 2, 0); step();
        aw_push = 0; wv_m[0] = 1; wl_m[0] = 1; wd_m[0] = 32'hDEADBEEF; ws_m[0] = 4'hF; wr_s[2] = 1;
        #3;
        chk("t1_wdata_s2", wd_s[2], 32'hDEADBEEF);
        chk("t1_wvalid", wv_s, 6'b000100);
        chk("t1_wready", wr_m, 2'b01);
        step(); #3;
        chk("t1_empty_wready", wr_m, 0);
        chk("t1_empty_wvalid", wv_s, 0);
        idle(); step();

        // Burst M2 -> S5 with toggling backpressure
        push(1, 5, 3); step();
        aw_push = 0; got = 0; errs = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            wr_s[5] = (c % 2 == 0); wv_m[1] = 1; wd_m[1] = 32'hA000_0000 + got; wl_m[1] = (got == 3);
            #3;
            chk("b_wready_mirror", wr_m[1], wr_s[5]);
            if (wv_s[5] && wr_s[5]) begin
                chk("b_data_order", wd_s[5], 32'hA000_0000 + got);
                got++;
            end
            step();
            if (wlast_err) errs++;
        end
        chk("b_beats", got, 4);
        chk("b_no_err", errs, 0);
        idle(); step();

        // Two queued AWs: M1->S1 len1, then M2->S3 len0
        push(0, 1, 1); step();
        push(1, 3, 0); step();
        aw_push = 0; wr_s[1] = 1; wr_s[3] = 1;
        wv_m[0] = 1; wl_m[0] = 0; wd_m[0] = 32'h1111_0000;
        wv_m[1] = 1; wl_m[1] = 1; wd_m[1] = 32'h3333_3333;
        #3;
        chk("q2_full", aw_full, 1);
        chk("q2_m2_held", {wv_s[3], wr_m[1]}, 0);
        chk("q2_s1_route", wv_s[1], 1);
        step();
        wl_m[0] = 1; wd_m[0] = 32'h1111_0001;
        #3;
        chk("q2_m2_held2", wv_s[3], 0);
        step();
        wv_m[0] = 0;
        #3;
        chk("q2_s3_after_pop", {wv_s[3], wr_m[1]}, 2'b11);
        chk("q2_s3_data", wd_s[3], 32'h3333_3333);
        step(); idle(); step();

        // Default slave, two beats from M1
        push(0, 6, 1); step();
        aw_push = 0; wr_s = 6'h3F; wv_m[0] = 1; wl_m[0] = 0;
        #3;
        chk("ds_b0_wready", wr_m[0], 1);
        chk("ds_b0_novalid", wv_s, 0);
        step();
        wl_m[0] = 1;
        #3;
        chk("ds_b1_wready", wr_m[0], 1);
        chk("ds_b1_novalid", wv_s, 0);
        step();
        wv_m[0] = 0;
        #3;
        chk("ds_done_pulse", ds_wdone, 1);
        step(); #3;
        chk("ds_done_clear", ds_wdone, 0);
        idle(); step();

        // Length mismatch: len 2, WLAST on the second beat; then M2->S4 len0
        push(0, 0, 2); step();
        push(1, 4, 0); step();
        aw_push = 0; wr_s[0] = 1; wr_s[4] = 1; wv_m[0] = 1; wl_m[0] = 0;
        step();
        wl_m[0] = 1;
        step();
        wv_m[0] = 0; wv_m[1] = 1; wl_m[1] = 1; wd_m[1] = 32'h4444_4444;
        #3;
        chk("lm_err_pulse", wlast_err, 1);
        chk("lm_next_route", wv_s, 6'b010000);
        chk("lm_next_data", wd_s[4], 32'h4444_4444);
        step(); #3;
        chk("lm_err_clear", wlast_err, 0);
        idle(); step();

        // Reset during beat 2 of 4
        push(1, 2, 3); step();
        aw_push = 0; wv_m[1] = 1; wr_s[2] = 1; wl_m[1] = 0; wd_m[1] = 32'h5555_0000;
        step();
        #2 rst = 0;
        #1;
        chk("rmb_wvalid", wv_s, 0);
        chk("rmb_wready", wr_m, 0);
        chk("rmb_full", aw_full, 0);
        chk("rmb_data", wd_s[2], 0);
        idle();
        step();
        #3 rst = 1;
        step();
        push(0, 0, 0); step();
        aw_push = 0; wv_m[0] = 1; wl_m[0] = 1; wd_m[0] = 32'h0A0A_0A0A; wr_s[0] = 1;
        #3;
        chk("rmb_after_route", wv_s, 6'b000001);
        chk("rmb_after_data", wd_s[0], 32'h0A0A_0A0A);
        step(); idle(); step();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            aw_push   = ($urandom % 3 == 0);
            aw_master = $urandom % 2;
            aw_slave  = $urandom % 8;
            aw_len    = $urandom % 4;
            for (int i = 0; i < 2; i++) begin
                wv_m[i] = ($urandom % 10 < 7);
                wl_m[i] = ($urandom % 3 == 0);
                wd_m[i] = $urandom;
                ws_m[i] = $urandom % 16;
            end
            wr_s = $urandom % 64;
            step();
        end

        idle();
        step(); step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
